// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory program loader.
package imem_pkg;

    // Default instruction word width and word-address width.
    localparam int IMEM_WIDTH      = 32;
    localparam int IMEM_ADDR_WIDTH = 7;

    // Bytes per instruction word; words arrive least-significant byte first.
    localparam int BYTES_PER_WORD  = IMEM_WIDTH / 8;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects a little-endian byte stream into one word. Each accepted byte
// lands in the lane selected by the byte index; word_done flags the byte
// that completes the word so the loader can issue the write next cycle.
module word_assembler
    import imem_pkg::*;
#(
    parameter int BPW = BYTES_PER_WORD
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [7:0]         byte_data,
    output logic [8*BPW-1:0]   word,
    output logic               word_done
);

    localparam int IW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

    logic [IW-1:0] byte_idx_reg;

    // The completing byte is the one accepted while the index sits on the last lane.
    assign word_done = shift_en && (byte_idx_reg == LAST_IDX);

    // Byte index: restarts on a new load and after each completed word.
    always_ff @(posedge clk) begin
        if (srst || clear || word_done) begin
            byte_idx_reg <= '0;
        end else if (shift_en) begin
            byte_idx_reg <= byte_idx_reg + 1'b1;
        end
    end

    // One byte-wide register per lane, written only when its index is current.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            logic [7:0] lane_reg;

            // Capture the accepted byte into this lane.
            always_ff @(posedge clk) begin
                if (srst) begin
                    lane_reg <= '0;
                end else if (shift_en && (byte_idx_reg == IW'(gi))) begin
                    lane_reg <= byte_data;
                end
            end

            assign word[8*gi +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// Program loader: turns a host byte stream into sequential instruction-memory
// writes starting at address 0, holding the CPU until the requested number
// of words has been written.
module imem_loader
    import imem_pkg::*;
#(
    parameter int n = IMEM_WIDTH,
    parameter int r = IMEM_ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [r:0]   wordCount,
    input  logic         byteValid,
    input  logic [7:0]   byteData,
    output logic         byteReady,
    output logic         memWrite,
    output logic [r-1:0] memAddr,
    output logic [n-1:0] memData,
    output logic         busy,
    output logic         done,
    output logic         cpuHold
);

    loader_state_t state_reg;

    // Word index is one bit wider than the address so a full-depth count terminates.
    logic [r:0]   count_reg;
    logic [r:0]   word_idx_reg;
    logic [r:0]   word_idx_inc;

    logic         byte_ready_reg;
    logic         mem_write_reg;
    logic         busy_reg;
    logic         done_reg;
    logic         cpu_hold_reg;

    logic         start_accept;
    logic         byte_accept;
    logic         word_done;
    logic [n-1:0] asm_word;

    assign start_accept = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign byte_accept  = byteValid && byte_ready_reg;
    assign word_idx_inc = word_idx_reg + 1'b1;

    word_assembler #(
        .BPW(n / 8)
    ) u_word_assembler (
        .clk       (clk),
        .srst      (reset),
        .clear     (start_accept),
        .shift_en  (byte_accept),
        .byte_data (byteData),
        .word      (asm_word),
        .word_done (word_done)
    );

    // Loader FSM with word counter and registered status/handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            word_idx_reg   <= '0;
            byte_ready_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            cpu_hold_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        count_reg    <= wordCount;
                        word_idx_reg <= '0;
                        if (wordCount == '0) begin
                            state_reg      <= DONE;
                            byte_ready_reg <= 1'b0;
                            busy_reg       <= 1'b0;
                            done_reg       <= 1'b1;
                            cpu_hold_reg   <= 1'b0;
                        end else begin
                            state_reg      <= RECV;
                            byte_ready_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                            done_reg       <= 1'b0;
                            cpu_hold_reg   <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (word_done) begin
                        state_reg      <= WRITE;
                        byte_ready_reg <= 1'b0;
                        mem_write_reg  <= 1'b1;
                    end
                end
                WRITE: begin
                    mem_write_reg <= 1'b0;
                    word_idx_reg  <= word_idx_inc;
                    if (word_idx_inc == count_reg) begin
                        state_reg    <= DONE;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        cpu_hold_reg <= 1'b0;
                    end else begin
                        state_reg      <= RECV;
                        byte_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    byte_ready_reg <= 1'b0;
                    mem_write_reg  <= 1'b0;
                    busy_reg       <= 1'b0;
                    done_reg       <= 1'b0;
                    cpu_hold_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign byteReady = byte_ready_reg;
    assign memWrite  = mem_write_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign cpuHold   = cpu_hold_reg;

    // Address and data are forced to zero outside the write strobe.
    assign memAddr   = mem_write_reg ? word_idx_reg[r-1:0] : '0;
    assign memData   = mem_write_reg ? asm_word : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int N = 32;
    localparam int R = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [R:0]   wordCount;
    logic         byteValid;
    logic [7:0]   byteData;
    logic         byteReady;
    logic         memWrite;
    logic [R-1:0] memAddr;
    logic [N-1:0] memData;
    logic         busy;
    logic         done;
    logic         cpuHold;

    int errors = 0;
    int checks = 0;

    // Write log filled by the monitor.
    logic [R-1:0] wr_addr [1024];
    logic [N-1:0] wr_data [1024];
    int           wr_n = 0;
    int           idle_bad = 0;

    imem_loader #(.n(N), .r(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .wordCount (wordCount),
        .byteValid (byteValid),
        .byteData  (byteData),
        .byteReady (byteReady),
        .memWrite  (memWrite),
        .memAddr   (memAddr),
        .memData   (memData),
        .busy      (busy),
        .done      (done),
        .cpuHold   (cpuHold)
    );

    always #5 clk = ~clk;

    // Log every write strobe; flag nonzero address/data outside a strobe.
    always @(negedge clk) begin
        if (memWrite === 1'b1) begin
            if (wr_n < 1024) begin
                wr_addr[wr_n] = memAddr;
                wr_data[wr_n] = memData;
            end
            wr_n = wr_n + 1;
            $display("write addr=%0d data=%08h", memAddr, memData);
        end else if (memAddr !== '0 || memData !== '0) begin
            idle_bad = idle_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [R:0] cnt);
        start     = 1'b1;
        wordCount = cnt;
        tick();
        start     = 1'b0;
        wordCount = 8'd99;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got       = 1'b0;
        byteValid = 1'b1;
        byteData  = b;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (byteReady === 1'b1) got = 1'b1;
            @(posedge clk);
            #1;
        end
        byteValid = 1'b0;
        byteData  = 8'h5A;
        if (!got) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (gap) begin
                byteData = 8'hFF;
                tick();
            end
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1) break;
            tick();
        end
        @(negedge clk);
        check(tag, {63'd0, done}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int w, input int k);
        return 8'(w * 3 + k * 69 + 1);
    endfunction

    initial begin
        int base;
        int bad;
        logic [31:0] exp_w;

        reset     = 1'b1;
        start     = 1'b0;
        wordCount = '0;
        byteValid = 1'b1;
        byteData  = 8'hAA;

        // 1: reset, then idle with byteValid held high
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("idle_byteReady", {63'd0, byteReady}, 64'd0);
        check("idle_memWrite",  {63'd0, memWrite},  64'd0);
        check("idle_cpuHold",   {63'd0, cpuHold},   64'd1);
        check("idle_done",      {63'd0, done},      64'd0);
        check("idle_busy",      {63'd0, busy},      64'd0);
        check("idle_no_write",  64'(wr_n),          64'd0);
        @(posedge clk);
        #1;
        byteValid = 1'b0;

        // 2: two words, back-to-back bytes
        base = wr_n;
        pulse_start(8'd2);
        @(negedge clk);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        send_word(32'h12345678, 1'b0);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        send_byte(8'hDE);
        @(negedge clk);
        check("b2b_last_strobe", {63'd0, memWrite}, 64'd1);
        check("b2b_last_addr",   64'(memAddr),      64'd1);
        check("b2b_last_data",   64'(memData),      64'hDEADBEEF);
        check("b2b_done_late",   {63'd0, done},     64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("b2b_done",    {63'd0, done},    64'd1);
        check("b2b_cpuHold", {63'd0, cpuHold}, 64'd0);
        check("b2b_busy_lo", {63'd0, busy},    64'd0);
        @(posedge clk);
        #1;
        check("b2b_count", 64'(wr_n - base), 64'd2);
        check("b2b_addr0", 64'(wr_addr[base]),     64'd0);
        check("b2b_data0", 64'(wr_data[base]),     64'h12345678);
        check("b2b_addr1", 64'(wr_addr[base + 1]), 64'd1);
        check("b2b_data1", 64'(wr_data[base + 1]), 64'hDEADBEEF);

        // 3: same load from DONE with byteValid toggling
        base = wr_n;
        pulse_start(8'd2);
        send_word(32'h12345678, 1'b1);
        send_word(32'hDEADBEEF, 1'b1);
        wait_done("gap_done");
        check("gap_count", 64'(wr_n - base), 64'd2);
        check("gap_addr0", 64'(wr_addr[base]),     64'd0);
        check("gap_data0", 64'(wr_data[base]),     64'h12345678);
        check("gap_addr1", 64'(wr_addr[base + 1]), 64'd1);
        check("gap_data1", 64'(wr_data[base + 1]), 64'hDEADBEEF);

        // 4: zero-word load from IDLE
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("zero_pre_done", {63'd0, done}, 64'd0);
        @(posedge clk);
        #1;
        base = wr_n;
        pulse_start(8'd0);
        @(negedge clk);
        check("zero_done",    {63'd0, done},    64'd1);
        check("zero_cpuHold", {63'd0, cpuHold}, 64'd0);
        check("zero_busy",    {63'd0, busy},    64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) tick();
        check("zero_no_write", 64'(wr_n - base), 64'd0);

        // 5: full-depth load of 128 words
        base = wr_n;
        pulse_start(8'd128);
        for (int w = 0; w < 128; w++) begin
            for (int k = 0; k < 4; k++) send_byte(pat(w, k));
        end
        wait_done("full_done");
        for (int i = 0; i < 10; i++) tick();
        check("full_count", 64'(wr_n - base), 64'd128);
        bad = 0;
        for (int w = 0; w < 128; w++) begin
            exp_w = {pat(w, 3), pat(w, 2), pat(w, 1), pat(w, 0)};
            if (wr_addr[base + w] !== 7'(w) || wr_data[base + w] !== exp_w) bad++;
        end
        check("full_words_bad", 64'(bad), 64'd0);
        check("full_last_addr", 64'(wr_addr[base + 127]), 64'h7F);
        @(negedge clk);
        check("full_ready_lo", {63'd0, byteReady}, 64'd0);
        @(posedge clk);
        #1;

        // 6: reset after two bytes of the second word
        base = wr_n;
        pulse_start(8'd2);
        send_word(32'hA1B2C3D4, 1'b0);
        send_byte(8'h01);
        send_byte(8'h02);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rst_count", 64'(wr_n - base), 64'd1);
        check("rst_data0", 64'(wr_data[base]), 64'hA1B2C3D4);
        @(negedge clk);
        check("rst_cpuHold", {63'd0, cpuHold},   64'd1);
        check("rst_done",    {63'd0, done},      64'd0);
        check("rst_ready",   {63'd0, byteReady}, 64'd0);
        check("rst_busy",    {63'd0, busy},      64'd0);
        @(posedge clk);
        #1;
        base = wr_n;
        pulse_start(8'd1);
        send_word(32'hCAFEF00D, 1'b0);
        wait_done("one_done");
        for (int i = 0; i < 4; i++) tick();
        check("one_count", 64'(wr_n - base), 64'd1);
        check("one_addr",  64'(wr_addr[base]), 64'd0);
        check("one_data",  64'(wr_data[base]), 64'hCAFEF00D);

        // 7: start pulsed during RECV is ignored
        base = wr_n;
        pulse_start(8'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start(8'd5);
        send_byte(8'h33);
        send_byte(8'h44);
        wait_done("ign_done");
        for (int i = 0; i < 10; i++) tick();
        check("ign_count",   64'(wr_n - base), 64'd1);
        check("ign_data",    64'(wr_data[base]), 64'h44332211);
        check("ign_addr",    64'(wr_addr[base]), 64'd0);
        check("ign_done_hi", {63'd0, done}, 64'd1);

        check("idle_bus_zero", 64'(idle_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the writable instruction memory before execution. Accepts a byte stream over a valid/ready handshake, assembles little-endian n-bit words, and issues one write per word at consecutive word addresses from 0. Sits between the host/boot link and the instruction memory's write port. Holds the CPU via `cpuHold` until the requested word count has been written.

## Interface
- `n`, 32, instruction word width in bits; must be a multiple of 8.
- `r`, 7, word-address width; memory depth is 2**r words.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- `wordCount`  input  r+1  number of words to load, 0..2**r; captured on accepted `start`.
- `byteValid`  input  1  `byteData` is valid this cycle.
- `byteData`  input  8  next program byte, least-significant byte of each word first.
- `byteReady`  output  1  loader accepts a byte this cycle.
- `memWrite`  output  1  write strobe to instruction memory.
- `memAddr`  output  r  word address for the write.
- `memData`  output  n  word to write.
- `busy`  output  1  load in progress (RECV or WRITE).
- `done`  output  1  requested count fully written.
- `cpuHold`  output  1  keep CPU stalled; high in every state except DONE.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: `cpuHold`=1, all other outputs 0. `start`=1 captures `wordCount` and clears the word index and byte index. Go to DONE if count is 0, else to RECV.
- RECV: `byteReady`=1. A byte transfers on `byteValid && byteReady`. It is placed at bits [8k+7:8k] of the assembly register, where k is the byte index.
  - After byte n/8-1 transfers, go to WRITE and reset the byte index.
  - With no `byteValid`, stay in RECV; nothing changes.
- WRITE: `byteReady`=0, `memWrite`=1 for exactly one cycle, `memAddr`=word index, `memData`=assembled word. Then increment the word index.
  - Go to DONE if the incremented index equals the count, else to RECV.
- DONE: `done`=1, `cpuHold`=0, `busy`=0. `start` re-enters as from IDLE and overwrites from address 0. Stay in DONE otherwise.
- `start` is ignored in RECV and WRITE.
- `byteData` outside a handshake is ignored.
- The word index is r+1 bits wide so a count of 2**r terminates correctly. `memAddr` carries its low r bits, with no wrap before termination.
- `memAddr` and `memData` are 0 whenever `memWrite`=0.

## Timing
- Reset (any state, including mid-word or during WRITE) takes effect at the next edge: state IDLE, indices 0, assembly register 0, `cpuHold`=1, all other outputs 0. The partial word is discarded and no write is issued.
- `start` at edge t: RECV (or DONE) is visible after t; `byteReady`=1 in the following cycle.
- Minimum time per word is n/8+1 cycles: n/8 byte cycles plus one WRITE bubble with `byteReady`=0.
- The last byte of a word is accepted at edge t. `memWrite`=1 during cycle t..t+1. `done` rises after edge t+1 if this was the last word.
- All outputs are registered or decoded from registered state only. There is no combinational path from `byteValid` to `byteReady`.

## Structure
- Shared package `imem_pkg`: loader state enum (IDLE, RECV, WRITE, DONE) and `BYTES_PER_WORD = n/8`.
- One sub-module: `word_assembler`, which holds the byte index, shifts bytes in, and flags word-complete. The FSM and word counter stay in `imem_loader`.

## Test plan
- Reset then idle with `byteValid`=1 → `byteReady`=0, `memWrite`=0, `cpuHold`=1, `done`=0.
- `start` with `wordCount`=2, bytes 78,56,34,12,EF,BE,AD,DE back-to-back → writes 0x12345678 at addr 0, then 0xDEADBEEF at addr 1. Exactly 2 `memWrite` pulses, then `done`=1 and `cpuHold`=0.
- Same load with `byteValid` toggling every other cycle → identical writes; no byte is lost or duplicated.
- `wordCount`=0 → DONE the cycle after `start` with no `memWrite`. A `wordCount`=128 load writes addrs 0..127 and then stops.
- `reset` after 2 bytes of the second word → no write to addr 1, return to IDLE. A new load of 1 word writes only addr 0.
- `start` pulsed during RECV → ignored; the count is unchanged and the load completes as originally requested.
